alu_issue_seq: RTL and testbench

Initiator side of the combinational ALU interface. Accepts ALU commands over a valid/ready handshake and reads operands from an internal register file. It drives A/B/ALUOp to an external ALU, captures C, writes it back to the register file and returns the result over a second valid/ready handshake. It sits between the test/control logic and the ALU as a minimal multi-cycle datapath.

---
 rtl/alu_issue_seq.sv | 133 +++++++++++++
 tb/tb_alu_issue_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// Multi-cycle issue sequencer for an external combinational ALU: accepts a command,
// reads operands from a local register file, captures the ALU result and returns it.
module alu_issue_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(NREG)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [$clog2(NREG)-1:0]  cmd_rd,
    input  logic [$clog2(NREG)-1:0]  cmd_rs,
    input  logic [$clog2(NREG)-1:0]  cmd_rt,
    input  logic                     cmd_use_imm,
    input  logic [15:0]              cmd_imm,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_op,
    input  logic [WIDTH-1:0]         alu_c,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [$clog2(NREG)-1:0]  res_rd,
    output logic                     res_err
);

    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  rf_q [NREG];
    logic [WIDTH-1:0]  alu_a_q, alu_b_q;
    logic [2:0]        alu_op_q;
    logic [AW-1:0]     rd_q;
    logic [WIDTH-1:0]  res_data_q;
    logic [AW-1:0]     res_rd_q;
    logic              res_err_q;

    logic [WIDTH-1:0]  opa_d, opb_d;
    logic              accept, op_illegal, wb_en;

    assign cmd_ready  = (state_q == IDLE);
    assign res_valid  = (state_q == RESP);
    assign accept     = cmd_valid && (state_q == IDLE);
    assign op_illegal = alu_op_q[2] & alu_op_q[1];
    assign wb_en      = (state_q == EXEC) && !op_illegal;

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign res_data = res_data_q;
    assign res_rd   = res_rd_q;
    assign res_err  = res_err_q;

    // Write-first operand read: a same-cycle external write bypasses the array.
    always_comb begin
        opa_d = '0;
        opb_d = '0;
        if (cmd_rs != '0) begin
            opa_d = (wr_en && wr_addr == cmd_rs) ? wr_data : rf_q[cmd_rs];
        end
        if (cmd_use_imm) begin
            opb_d = {{(WIDTH-16){1'b0}}, cmd_imm};
        end else if (cmd_rt != '0) begin
            opb_d = (wr_en && wr_addr == cmd_rt) ? wr_data : rf_q[cmd_rt];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            res_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q  <= opa_d;
                alu_b_q  <= opb_d;
                alu_op_q <= cmd_op;
                rd_q     <= cmd_rd;
            end
            if (state_q == EXEC) begin
                res_data_q <= op_illegal ? '0 : alu_c;
                res_err_q  <= op_illegal;
                res_rd_q   <= rd_q;
            end
        end
    end

    // Entry 0 is never written; internal writeback takes priority over an external write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (wb_en && rd_q == AW'(i)) begin
                    rf_q[i] <= alu_c;
                end else if (wr_en && wr_addr == AW'(i)) begin
                    rf_q[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: vector table plus hand-written hazard,
// backpressure and asynchronous-reset sequences, with a behavioural ALU attached.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op, cmd_rd, cmd_rs, cmd_rt;
    logic        cmd_use_imm;
    logic [15:0] cmd_imm;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_rd;
    logic        res_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_seq #(.WIDTH(32), .NREG(8)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .res_err(res_err)
    );

    // External ALU; illegal opcodes return a junk value that must never surface.
    always_comb begin
        alu_c = 32'hDEADBEEF;
        case (alu_op)
            3'b000: alu_c = alu_a + alu_b;
            3'b001: alu_c = alu_a - alu_b;
            3'b010: alu_c = alu_a & alu_b;
            3'b011: alu_c = alu_a | alu_b;
            3'b100: alu_c = (alu_b >= 32) ? 32'h0 : (alu_a >> alu_b[4:0]);
            3'b101: alu_c = (alu_b >= 32) ? {32{alu_a[31]}} : 32'($signed(alu_a) >>> alu_b[4:0]);
            default: alu_c = 32'hDEADBEEF;
        endcase
    end

    typedef struct packed {
        logic        pre_we;
        logic [2:0]  pre_a;
        logic [31:0] pre_d;
        logic [2:0]  op, rd, rs, rt;
        logic        ue;
        logic [15:0] imm;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_cmd(input logic [2:0] op, rd, rs, rt, input logic ue, input logic [15:0] imm,
                          input logic awe, input logic [2:0] aa, input logic [31:0] ad,
                          input logic ewe, input logic [2:0] ea, input logic [31:0] ed,
                          output logic [31:0] d, output logic [2:0] r, output logic e,
                          output int lat);
        int budget = 0;
        cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_use_imm = ue; cmd_imm = imm;
        cmd_valid = 1'b1;
        wr_en = awe; wr_addr = aa; wr_data = ad;
        while (!cmd_ready && budget < 10) begin
            @(posedge clk); #1;
            budget++;
        end
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_en = ewe; wr_addr = ea; wr_data = ed;
        lat = 1;
        while (!res_valid && lat < 10) begin
            @(posedge clk); #1;
            wr_en = 1'b0;
            lat++;
        end
        wr_en = 1'b0;
        d = res_data; r = res_rd; e = res_err;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic run_simple(input string name, input logic [2:0] op, rd, rs, rt, input logic ue,
                              input logic [15:0] imm, input logic [31:0] exp_d);
        logic [31:0] d;
        logic [2:0]  r;
        logic        e;
        int          lat;
        do_cmd(op, rd, rs, rt, ue, imm, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, d, r, e, lat);
        check(name, d, exp_d);
    endtask

    logic [31:0] got_d;
    logic [2:0]  got_r;
    logic        got_e;
    int          got_lat;

    initial begin
        //             we    a     d               op     rd    rs    rt   ue    imm        exp_d          e
        vecs[0]  = '{1'b0, 3'd0, 32'h0,        3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0,  32'h00000008, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 32'h0,        3'b011, 3'd4, 3'd3, 3'd0, 1'b1, 16'h10, 32'h00000018, 1'b0};
        vecs[2]  = '{1'b1, 3'd1, 32'h80000000, 3'b101, 3'd5, 3'd1, 3'd0, 1'b1, 16'd4,  32'hF8000000, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 32'h0,        3'b100, 3'd6, 3'd1, 3'd0, 1'b1, 16'd4,  32'h08000000, 1'b0};
        vecs[4]  = '{1'b1, 3'd1, 32'h1,        3'b001, 3'd7, 3'd0, 3'd1, 1'b0, 16'h0,  32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 32'h0,        3'b110, 3'd2, 3'd1, 3'd1, 1'b0, 16'h0,  32'h00000000, 1'b1};
        vecs[6]  = '{1'b0, 3'd0, 32'h0,        3'b000, 3'd5, 3'd2, 3'd0, 1'b0, 16'h0,  32'h00000003, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 32'h0,        3'b010, 3'd0, 3'd7, 3'd4, 1'b0, 16'h0,  32'h00000018, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 32'h0,        3'b011, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0,  32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 32'h0,        3'b111, 3'd3, 3'd1, 3'd1, 1'b0, 16'h0,  32'h00000000, 1'b1};
        vecs[10] = '{1'b1, 3'd1, 32'h80000000, 3'b101, 3'd2, 3'd1, 3'd0, 1'b1, 16'd40, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 32'h0,        3'b100, 3'd2, 3'd1, 3'd0, 1'b1, 16'd32, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 32'h0,        3'b001, 3'd2, 3'd3, 3'd7, 1'b0, 16'h0,  32'h00000009, 1'b0};
        vecs[13] = '{1'b0, 3'd0, 32'h0,        3'b000, 3'd4, 3'd7, 3'd7, 1'b0, 16'h0,  32'hFFFFFFFE, 1'b0};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
        cmd_use_imm = 1'b0; cmd_imm = '0; res_ready = 1'b0;
        #23;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_rd_err", {28'd0, res_err, res_rd}, 32'd0);
        check("rst_alu_ab", alu_a | alu_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        wr_reg(3'd1, 32'd5);
        wr_reg(3'd2, 32'd3);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].pre_we) wr_reg(vecs[i].pre_a, vecs[i].pre_d);
            do_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].ue, vecs[i].imm,
                   1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, got_d, got_r, got_e, got_lat);
            check($sformatf("vec%0d_data", i), got_d, vecs[i].exp_d);
            check($sformatf("vec%0d_rd", i), 32'(got_r), 32'(vecs[i].rd));
            check($sformatf("vec%0d_err", i), 32'(got_e), 32'(vecs[i].exp_e));
            check($sformatf("vec%0d_latency", i), 32'(got_lat), 32'd2);
        end

        // Backpressure with a second command already waiting
        cmd_op = 3'b011; cmd_rd = 3'd1; cmd_rs = 3'd0; cmd_use_imm = 1'b1; cmd_imm = 16'h55;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = 3'b000; cmd_rd = 3'd2; cmd_rs = 3'd1; cmd_imm = 16'h1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_valid", k), 32'(res_valid), 32'd1);
            check($sformatf("bp%0d_data", k), res_data, 32'h55);
            check($sformatf("bp%0d_rd", k), 32'(res_rd), 32'd1);
            check($sformatf("bp%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("bp_after_hs_ready", 32'(cmd_ready), 32'd1);
        check("bp_after_hs_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp_second_accepted", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("bp_second_valid", 32'(res_valid), 32'd1);
        check("bp_second_data", res_data, 32'h56);
        check("bp_second_rd", 32'(res_rd), 32'd2);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Hazards: write-first operand, writeback collision, independent writes in EXEC
        do_cmd(3'b000, 3'd2, 3'd1, 3'd0, 1'b1, 16'd1, 1'b1, 3'd1, 32'd7, 1'b0, 3'd0, 32'd0,
               got_d, got_r, got_e, got_lat);
        check("haz_bypass", got_d, 32'd8);
        do_cmd(3'b000, 3'd3, 3'd0, 3'd0, 1'b1, 16'd42, 1'b0, 3'd0, 32'd0, 1'b1, 3'd3, 32'd99,
               got_d, got_r, got_e, got_lat);
        check("haz_collide_res", got_d, 32'd42);
        run_simple("haz_collide_r3", 3'b011, 3'd4, 3'd3, 3'd0, 1'b1, 16'd0, 32'd42);
        do_cmd(3'b000, 3'd3, 3'd0, 3'd0, 1'b1, 16'd5, 1'b0, 3'd0, 32'd0, 1'b1, 3'd5, 32'd77,
               got_d, got_r, got_e, got_lat);
        run_simple("haz_both_written", 3'b000, 3'd6, 3'd5, 3'd3, 1'b0, 16'd0, 32'd82);

        // Asynchronous reset during EXEC
        cmd_op = 3'b000; cmd_rd = 3'd1; cmd_rs = 3'd0; cmd_use_imm = 1'b1; cmd_imm = 16'd9;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_exec_valid", 32'(res_valid), 32'd0);
        check("rst_exec_ready", 32'(cmd_ready), 32'd1);
        check("rst_exec_alu_a_b", alu_a | alu_b, 32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        run_simple("rst_exec_regs", 3'b000, 3'd2, 3'd3, 3'd5, 1'b0, 16'd0, 32'd0);

        // Asynchronous reset during RESP
        cmd_op = 3'b011; cmd_rd = 3'd4; cmd_rs = 3'd0; cmd_use_imm = 1'b1; cmd_imm = 16'h33;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_resp_pre_valid", 32'(res_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_resp_valid", 32'(res_valid), 32'd0);
        check("rst_resp_ready", 32'(cmd_ready), 32'd1);
        check("rst_resp_data", res_data, 32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        run_simple("rst_resp_regs", 3'b000, 3'd5, 3'd6, 3'd4, 1'b0, 16'd0, 32'd0);
        run_simple("rst_resp_r1", 3'b011, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
